// File: rtl/core_mem_responder_pkg.sv
// Shared types for the memory responder: FSM state encoding and port identifiers.
package core_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

endpackage

// File: rtl/core_mem_responder_if.sv
// Fetch and data request/response bundle between a core (master) and the memory responder (slave).
// Handshake: each req is held high until its ack; ack is a one-cycle pulse with rdata valid in that cycle.
interface core_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_we;
  logic                  dm_req;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_ack;
  logic                  addr_err;
  logic                  busy;

  modport master (
    output if_addr, if_req, dm_addr, dm_wdata, dm_we, dm_req,
    input  if_rdata, if_ack, dm_rdata, dm_ack, addr_err, busy
  );

  modport slave (
    input  if_addr, if_req, dm_addr, dm_wdata, dm_we, dm_req,
    output if_rdata, if_ack, dm_rdata, dm_ack, addr_err, busy
  );
endinterface

// File: rtl/core_mem_responder_array.sv
// Word-addressed storage with one synchronous read/write port; contents survive reset.
module core_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

// File: rtl/core_mem_responder.sv
// Two-port (fetch/data) memory responder: round-robin arbitration, programmable wait latency,
// range checking, and a single backing array accessed on the edge that enters RESP.
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  core_mem_responder_if.slave    bus,
  output state_e                 fsm_state
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e                state;
  logic [3:0]            cnt;
  port_e                 gnt;
  port_e                 last_grant;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  cap_we;
  logic                  if_ack_q, dm_ack_q, addr_err_q, resp_zero;
  logic [DATA_WIDTH-1:0] mem_q;

  logic                  start, pick_dm, enter_resp, enter_dm;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we, mem_oor, mem_en;

  // On a tie the port that did not win last time is granted.
  assign start   = (state == IDLE) && (bus.if_req || bus.dm_req);
  assign pick_dm = bus.dm_req && (!bus.if_req || last_grant == PORT_IF);

  // With zero wait the array is accessed on the grant edge itself, straight from the inputs.
  assign mem_addr  = (state == IDLE) ? (pick_dm ? bus.dm_addr : bus.if_addr) : cap_addr;
  assign mem_wdata = (state == IDLE) ? bus.dm_wdata : cap_wdata;
  assign mem_we    = (state == IDLE) ? (pick_dm && bus.dm_we) : cap_we;
  assign mem_oor   = (mem_addr >> (IDX_W + 2)) != '0;

  assign enter_resp = (start && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
  assign enter_dm   = (state == IDLE) ? pick_dm : (gnt == PORT_DM);
  assign mem_en     = !rst && enter_resp && !mem_oor;

  core_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr[IDX_W+1:2]),
    .wdata (mem_wdata),
    .rdata (mem_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= PORT_IF;
      last_grant <= PORT_DM;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_we     <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      addr_err_q <= 1'b0;
      resp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gnt        <= pick_dm ? PORT_DM : PORT_IF;
            last_grant <= pick_dm ? PORT_DM : PORT_IF;
            cap_addr   <= mem_addr;
            cap_wdata  <= mem_wdata;
            cap_we     <= mem_we;
            cnt        <= WAIT_INIT;
            state      <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if_ack_q   <= 1'b0;
          dm_ack_q   <= 1'b0;
          addr_err_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        if_ack_q   <= !enter_dm;
        dm_ack_q   <= enter_dm;
        addr_err_q <= mem_oor;
        resp_zero  <= mem_oor || mem_we;
      end
    end
  end

  // Read data is forced to zero outside the ack cycle, on writes, and on range errors.
  assign bus.if_ack   = if_ack_q;
  assign bus.dm_ack   = dm_ack_q;
  assign bus.if_rdata = (if_ack_q && !resp_zero) ? mem_q : '0;
  assign bus.dm_rdata = (dm_ack_q && !resp_zero) ? mem_q : '0;
  assign bus.addr_err = addr_err_q;
  assign bus.busy     = (state != IDLE);
  assign fsm_state    = state;
endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: one DUT with WAIT_CYCLES=1, one with WAIT_CYCLES=0.
module tb_core_mem_responder;
  import core_mem_pkg::*;

  logic clk;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;
  state_e st1, st0;

  core_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();
  core_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b0 ();

  core_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .fsm_state(st1));
  core_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .fsm_state(st0));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: one transaction on the WAIT_CYCLES=1 DUT; lat counts negedges until ack, -1 on timeout
  task automatic tx1(input bit dm, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output bit err, output int lat, output bit clash);
    bit done = 1'b0;
    rdata = '0; err = 1'b0; lat = -1; clash = 1'b0;
    @(negedge clk);
    if (dm) begin
      b1.dm_addr = addr; b1.dm_wdata = wdata; b1.dm_we = we; b1.dm_req = 1'b1;
    end else begin
      b1.if_addr = addr; b1.if_req = 1'b1;
    end
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge clk);
      if (dm ? b1.if_ack : b1.dm_ack) clash = 1'b1;
      if (dm ? b1.dm_ack : b1.if_ack) begin
        rdata = dm ? b1.dm_rdata : b1.if_rdata;
        err   = b1.addr_err;
        lat   = i;
        done  = 1'b1;
      end
    end
    b1.if_req = 1'b0;
    b1.dm_req = 1'b0;
  endtask

  // driver: data-port write on the WAIT_CYCLES=0 DUT
  task automatic wr0(input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    bit done = 1'b0;
    lat = -1;
    @(negedge clk);
    b0.dm_addr = addr; b0.dm_wdata = wdata; b0.dm_we = 1'b1; b0.dm_req = 1'b1;
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge clk);
      if (b0.dm_ack) begin
        lat = i;
        done = 1'b1;
      end
    end
    b0.dm_req = 1'b0;
    b0.dm_we  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++;
    if ({b1.if_ack, b1.dm_ack, b1.addr_err, b1.busy} !== 4'b0 || b1.if_rdata !== 32'h0 || b1.dm_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL reset_outputs: got acks/err/busy=%b rdata=%h/%h, expected 0000 and 0", 
               {b1.if_ack, b1.dm_ack, b1.addr_err, b1.busy}, b1.if_rdata, b1.dm_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (st1 !== IDLE || b1.busy !== 1'b0 || st0 !== IDLE) begin
      nerr++;
      $display("FAIL reset_state: got %0d/%0d busy=%b, expected IDLE/IDLE busy=0", st1, st0, b1.busy);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; bit err, clash; int lat;
    tx1(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, rd, err, lat, clash);
    nvec++;
    if (lat !== 2 || rd !== 32'h0 || err !== 1'b0 || clash !== 1'b0) begin
      nerr++;
      $display("FAIL write_0x10: got lat=%0d rdata=%h err=%b clash=%b, expected lat=2 rdata=0 err=0 clash=0", lat, rd, err, clash);
    end
    tx1(1'b0, 1'b0, 32'h10, 32'h0, rd, err, lat, clash);
    nvec++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || err !== 1'b0 || clash !== 1'b0) begin
      nerr++;
      $display("FAIL if_read_0x10: got lat=%0d rdata=%h err=%b clash=%b, expected lat=2 rdata=deadbeef err=0 clash=0", lat, rd, err, clash);
    end
    tx1(1'b1, 1'b0, 32'h13, 32'h0, rd, err, lat, clash);
    nvec++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || err !== 1'b0) begin
      nerr++;
      $display("FAIL dm_read_0x13: got lat=%0d rdata=%h err=%b, expected lat=2 rdata=deadbeef err=0", lat, rd, err);
    end
  endtask

  // both ports request on the same edge; check who is acked first and the bubble between acks
  task automatic tie_round(input bit exp_dm_first, input string tag);
    bit got_if = 0, got_dm = 0, clash = 0, first_dm = 0;
    int t_if = 0, t_dm = 0, gap;
    logic [31:0] rd_if = '0, rd_dm = '0;
    @(negedge clk);
    b1.if_addr = 32'h10; b1.dm_addr = 32'h10; b1.dm_we = 1'b0;
    b1.if_req = 1'b1; b1.dm_req = 1'b1;
    for (int i = 1; i <= 30 && !(got_if && got_dm); i++) begin
      @(negedge clk);
      if (b1.if_ack && b1.dm_ack) clash = 1'b1;
      if (b1.if_ack && !got_if) begin
        got_if = 1'b1; t_if = i; rd_if = b1.if_rdata; b1.if_req = 1'b0;
        if (!got_dm) first_dm = 1'b0;
      end
      if (b1.dm_ack && !got_dm) begin
        got_dm = 1'b1; t_dm = i; rd_dm = b1.dm_rdata; b1.dm_req = 1'b0;
        if (!got_if) first_dm = 1'b1;
      end
    end
    b1.if_req = 1'b0; b1.dm_req = 1'b0;
    gap = exp_dm_first ? (t_if - t_dm) : (t_dm - t_if);
    nvec++;
    if (!got_if || !got_dm || clash || first_dm !== exp_dm_first || gap != 3) begin
      nerr++;
      $display("FAIL %s: got if=%b dm=%b clash=%b dm_first=%b gap=%0d, expected 1 1 0 dm_first=%b gap=3",
               tag, got_if, got_dm, clash, first_dm, gap, exp_dm_first);
    end
    nvec++;
    if (rd_if !== 32'hDEADBEEF || rd_dm !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL %s_data: got %h/%h, expected deadbeef/deadbeef", tag, rd_if, rd_dm);
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] rd; bit err, clash; int lat;
    pulse_reset();
    tie_round(1'b0, "tie_after_reset");
    tie_round(1'b0, "tie_repeat");
    tx1(1'b0, 1'b0, 32'h10, 32'h0, rd, err, lat, clash);
    tie_round(1'b1, "tie_after_if_grant");
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; bit err, clash; int lat;
    tx1(1'b1, 1'b1, 32'h0, 32'h11111111, rd, err, lat, clash);
    tx1(1'b1, 1'b0, 32'h0001_0000, 32'h0, rd, err, lat, clash);
    nvec++;
    if (lat !== 2 || rd !== 32'h0 || err !== 1'b1) begin
      nerr++;
      $display("FAIL oor_read: got lat=%0d rdata=%h err=%b, expected lat=2 rdata=0 err=1", lat, rd, err);
    end
    tx1(1'b1, 1'b1, 32'h0001_0000, 32'hFFFF_FFFF, rd, err, lat, clash);
    nvec++;
    if (lat !== 2 || err !== 1'b1) begin
      nerr++;
      $display("FAIL oor_write: got lat=%0d err=%b, expected lat=2 err=1", lat, err);
    end
    tx1(1'b0, 1'b0, 32'h0, 32'h0, rd, err, lat, clash);
    nvec++;
    if (rd !== 32'h11111111 || err !== 1'b0) begin
      nerr++;
      $display("FAIL oor_array_unchanged: got %h err=%b, expected 11111111 err=0", rd, err);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; bit err, clash, seen_ack = 1'b0; int lat;
    tx1(1'b1, 1'b1, 32'h20, 32'hAAAA5555, rd, err, lat, clash);
    @(negedge clk);
    b1.dm_addr = 32'h20; b1.dm_wdata = 32'h12345678; b1.dm_we = 1'b1; b1.dm_req = 1'b1;
    @(negedge clk);
    nvec++;
    if (st1 !== WAIT || b1.busy !== 1'b1) begin
      nerr++;
      $display("FAIL abort_in_wait: got state=%0d busy=%b, expected WAIT busy=1", st1, b1.busy);
    end
    rst = 1'b1;
    b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    #1;
    nvec++;
    if (st1 !== IDLE || b1.busy !== 1'b0) begin
      nerr++;
      $display("FAIL abort_async: got state=%0d busy=%b, expected IDLE busy=0", st1, b1.busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      if (b1.dm_ack || b1.if_ack) seen_ack = 1'b1;
    end
    nvec++;
    if (seen_ack !== 1'b0) begin
      nerr++;
      $display("FAIL abort_no_ack: got ack seen=%b, expected 0", seen_ack);
    end
    tx1(1'b0, 1'b0, 32'h20, 32'h0, rd, err, lat, clash);
    nvec++;
    if (rd !== 32'hAAAA5555) begin
      nerr++;
      $display("FAIL abort_no_commit: got %h, expected aaaa5555", rd);
    end
  endtask

  task automatic test_capture();
    logic [31:0] rd; bit err, clash, done = 1'b0; int lat;
    tx1(1'b1, 1'b1, 32'h34, 32'h5, rd, err, lat, clash);
    @(negedge clk);
    b1.dm_addr = 32'h30; b1.dm_wdata = 32'hCAFEF00D; b1.dm_we = 1'b1; b1.dm_req = 1'b1;
    @(negedge clk);
    b1.dm_addr = 32'h34; b1.dm_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 20 && !done; i++) begin
      if (b1.dm_ack) done = 1'b1;
      else @(negedge clk);
    end
    b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    nvec++;
    if (!done) begin
      nerr++;
      $display("FAIL capture_ack: got no dm_ack, expected one within 20 cycles");
    end
    tx1(1'b0, 1'b0, 32'h30, 32'h0, rd, err, lat, clash);
    nvec++;
    if (rd !== 32'hCAFEF00D) begin
      nerr++;
      $display("FAIL capture_addr_0x30: got %h, expected cafef00d", rd);
    end
    tx1(1'b0, 1'b0, 32'h34, 32'h0, rd, err, lat, clash);
    nvec++;
    if (rd !== 32'h5) begin
      nerr++;
      $display("FAIL capture_addr_0x34: got %h, expected 00000005", rd);
    end
  endtask

  task automatic test_back_to_back_wait0();
    logic [31:0] exp_q[$];
    int lat, k = 0, last = 0, bad_lat = 0;
    exp_q = '{32'hA0A0_0000, 32'hA4A4_0004, 32'hA8A8_0008};
    for (int j = 0; j < 3; j++) begin
      wr0(32'(j * 4), exp_q[j], lat);
      if (lat != 1) bad_lat++;
    end
    nvec++;
    if (bad_lat != 0) begin
      nerr++;
      $display("FAIL wait0_write_latency: got %0d writes with latency != 1, expected 0", bad_lat);
    end
    @(negedge clk);
    b0.if_addr = 32'h0; b0.if_req = 1'b1;
    for (int i = 1; i <= 40 && k < 3; i++) begin
      @(negedge clk);
      if (b0.if_ack) begin
        nvec++;
        if (b0.if_rdata !== exp_q[k] || (k > 0 && i - last != 2) || (k == 0 && i != 1)) begin
          nerr++;
          $display("FAIL wait0_read_%0d: got data=%h at cycle %0d (prev %0d), expected %h spaced by 2",
                   k, b0.if_rdata, i, last, exp_q[k]);
        end
        last = i;
        k++;
        if (k < 3) b0.if_addr = 32'(k * 4);
        else b0.if_req = 1'b0;
      end
    end
    b0.if_req = 1'b0;
    nvec++;
    if (k != 3) begin
      nerr++;
      $display("FAIL wait0_timeout: got %0d acks, expected 3", k);
    end
  endtask

  initial begin
    rst = 1'b1;
    b1.if_addr = '0; b1.if_req = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0; b1.dm_we = 1'b0; b1.dm_req = 1'b0;
    b0.if_addr = '0; b0.if_req = 1'b0; b0.dm_addr = '0; b0.dm_wdata = '0; b0.dm_we = 1'b0; b0.dm_req = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_arbitration();
    test_out_of_range();
    test_reset_abort();
    test_capture();
    test_back_to_back_wait0();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
